// File: rtl/branch_predict_unit_pkg.sv
// Shared constants for the branch predictor: default widths, BTB tag sizing
// and the reset value of the global pattern table counters.
package branch_predict_unit_pkg;

    localparam int PC_WIDTH           = 32;
    localparam int DEF_GLOBAL_WIDTH   = 8;
    localparam int DEF_LOCAL_WIDTH    = 4;
    localparam int DEF_BTB_SET_WIDTH  = 6;
    localparam int DEF_BTB_WAY_NUM    = 1;
    localparam int DEF_B_PATTEN_WIDTH = 2;
    localparam int DEF_G_PATTEN_WIDTH = 2;
    localparam int DEF_RAS_DEPTH      = 8;

    function automatic int tag_width(input int set_width);
        return PC_WIDTH - set_width - 2;
    endfunction

    // Weakly-not-taken: MSB clear, all lower bits set (2'b01 for 2-bit counters).
    function automatic logic [31:0] weak_not_taken(input int width);
        return (32'd1 << (width - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch-side prediction bundle and execute-side resolution/fill bundle.
// master = PC generator / execute side, slave = branch_predict_unit.
interface branch_predict_unit_if #(
    parameter int GLOBAL_WIDTH   = 8,
    parameter int LOCAL_WIDTH    = 4,
    parameter int BTB_WAY_NUM    = 1,
    parameter int B_PATTEN_WIDTH = 2,
    parameter int G_PATTEN_WIDTH = 2
);
    localparam int TAB_WIDTH = B_PATTEN_WIDTH * (2 ** LOCAL_WIDTH);

    logic                      stall;
    logic [31:0]               fetch_pc;
    logic                      predict_is_branch;
    logic [31:0]               predict_address;
    logic [BTB_WAY_NUM-1:0]    btb_way_vec;
    logic [LOCAL_WIDTH-1:0]    pht_history;
    logic [TAB_WIDTH-1:0]      pht_patten_tab;
    logic [GLOBAL_WIDTH-1:0]   ghr;
    logic [G_PATTEN_WIDTH-1:0] ghr_patten;

    logic                      update_valid;
    logic                      is_jump_branch;
    logic [31:0]               fail_branch;
    logic [BTB_WAY_NUM-1:0]    fail_way_vec;
    logic [31:0]               fill_target;
    logic                      fill_is_ret;
    logic                      fill_is_link;
    logic [LOCAL_WIDTH-1:0]    fill_pht_history;
    logic [TAB_WIDTH-1:0]      fill_pht_patten_tab;
    logic [GLOBAL_WIDTH-1:0]   fail_ghr;
    logic [GLOBAL_WIDTH-1:0]   fill_ghr;
    logic [G_PATTEN_WIDTH-1:0] fill_ghr_patten;

    modport master (
        output stall, fetch_pc, update_valid, is_jump_branch, fail_branch, fail_way_vec,
               fill_target, fill_is_ret, fill_is_link, fill_pht_history, fill_pht_patten_tab,
               fail_ghr, fill_ghr, fill_ghr_patten,
        input  predict_is_branch, predict_address, btb_way_vec, pht_history, pht_patten_tab,
               ghr, ghr_patten
    );

    modport slave (
        input  stall, fetch_pc, update_valid, is_jump_branch, fail_branch, fail_way_vec,
               fill_target, fill_is_ret, fill_is_link, fill_pht_history, fill_pht_patten_tab,
               fail_ghr, fill_ghr, fill_ghr_patten,
        output predict_is_branch, predict_address, btb_way_vec, pht_history, pht_patten_tab,
               ghr, ghr_patten
    );

endinterface

// File: rtl/bpu_ras.sv
// Return-address stack used when BPU_RAS_EN is defined. Pointer wraps both
// ways: overflow overwrites the oldest entry, underflow returns stale data.
module bpu_ras #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic [DATA_WIDTH-1:0] top_data
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0]      ptr_q;
    logic [PTR_W-1:0]      top_idx;
    logic [DATA_WIDTH-1:0] stack [DEPTH];

    assign top_idx  = ptr_q - 1'b1;
    assign top_data = stack[top_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else if (push && !pop) begin
            ptr_q <= ptr_q + 1'b1;
        end else if (pop && !push) begin
            ptr_q <= top_idx;
        end
    end

    // Simultaneous push and pop replaces the top entry in place.
    always_ff @(posedge clk) begin
        if (push && pop) begin
            stack[top_idx] <= push_data;
        end else if (push) begin
            stack[ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Fetch-side predictor: BTB with per-entry local history/pattern table plus GHR-indexed
// global pattern table. Optional return-address stack under macro BPU_RAS_EN.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int GLOBAL_WIDTH   = DEF_GLOBAL_WIDTH,
    parameter int LOCAL_WIDTH    = DEF_LOCAL_WIDTH,
    parameter int BTB_SET_WIDTH  = DEF_BTB_SET_WIDTH,
    parameter int BTB_WAY_NUM    = DEF_BTB_WAY_NUM,
    parameter int B_PATTEN_WIDTH = DEF_B_PATTEN_WIDTH,
    parameter int G_PATTEN_WIDTH = DEF_G_PATTEN_WIDTH,
    parameter int RAS_DEPTH      = DEF_RAS_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    branch_predict_unit_if.slave bus
);
    localparam int SETS      = 2 ** BTB_SET_WIDTH;
    localparam int TAG_W     = tag_width(BTB_SET_WIDTH);
    localparam int TAB_W     = B_PATTEN_WIDTH * (2 ** LOCAL_WIDTH);
    localparam int GPT_N     = 2 ** GLOBAL_WIDTH;
    localparam int WAY_W     = (BTB_WAY_NUM > 1) ? $clog2(BTB_WAY_NUM) : 1;
    localparam logic [G_PATTEN_WIDTH-1:0] GPT_RESET = G_PATTEN_WIDTH'(weak_not_taken(G_PATTEN_WIDTH));

    logic                      btb_valid  [SETS][BTB_WAY_NUM];
    logic [TAG_W-1:0]          btb_tag    [SETS][BTB_WAY_NUM];
    logic [31:0]               btb_target [SETS][BTB_WAY_NUM];
    logic                      btb_ret    [SETS][BTB_WAY_NUM];
    logic                      btb_link   [SETS][BTB_WAY_NUM];
    logic [LOCAL_WIDTH-1:0]    btb_hist   [SETS][BTB_WAY_NUM];
    logic [TAB_W-1:0]          btb_tab    [SETS][BTB_WAY_NUM];
    logic [G_PATTEN_WIDTH-1:0] gpt        [GPT_N];
    logic [GLOBAL_WIDTH-1:0]   ghr_q;
    logic [WAY_W-1:0]          rr_q;

    logic [BTB_SET_WIDTH-1:0]  look_set, upd_set;
    logic [TAG_W-1:0]          look_tag, upd_tag;
    logic                      hit;
    logic [WAY_W-1:0]          hit_way, upd_way, wr_way;
    logic [BTB_WAY_NUM-1:0]    way_vec;
    logic [B_PATTEN_WIDTH-1:0] local_ctr;
    logic [G_PATTEN_WIDTH-1:0] global_ctr;
    logic                      local_strong, dir, use_ras, redirect, upd_existing, upd_alloc;
    logic [31:0]               pc_plus8, ras_top, next_addr;
    logic                      unused_pc_bits;

    assign look_set = bus.fetch_pc[BTB_SET_WIDTH+1:2];
    assign look_tag = bus.fetch_pc[31:BTB_SET_WIDTH+2];
    assign upd_set  = bus.fail_branch[BTB_SET_WIDTH+1:2];
    assign upd_tag  = bus.fail_branch[31:BTB_SET_WIDTH+2];
    assign pc_plus8 = bus.fetch_pc + 32'd8;
    assign redirect = bus.is_jump_branch;
    assign unused_pc_bits = ^bus.fail_branch[1:0];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        way_vec = '0;
        for (int w = 0; w < BTB_WAY_NUM; w++) begin
            if (!hit && btb_valid[look_set][w] && btb_tag[look_set][w] == look_tag) begin
                hit        = 1'b1;
                hit_way    = WAY_W'(w);
                way_vec[w] = 1'b1;
            end
        end
    end

    assign local_ctr    = btb_tab[look_set][hit_way][int'(btb_hist[look_set][hit_way]) * B_PATTEN_WIDTH +: B_PATTEN_WIDTH];
    assign global_ctr   = gpt[ghr_q ^ bus.fetch_pc[GLOBAL_WIDTH+1:2]];
    assign local_strong = (local_ctr == '0) || (&local_ctr);
    assign dir          = hit && (local_strong ? local_ctr[B_PATTEN_WIDTH-1] : global_ctr[G_PATTEN_WIDTH-1]);

`ifdef BPU_RAS_EN
    logic ras_push, ras_pop;
    assign use_ras  = btb_ret[look_set][hit_way];
    assign ras_push = hit && btb_link[look_set][hit_way] && !bus.stall && !redirect;
    assign ras_pop  = hit && use_ras && !bus.stall && !redirect;

    bpu_ras #(.DEPTH(RAS_DEPTH), .DATA_WIDTH(32)) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus8),
        .top_data  (ras_top)
    );
`else
    localparam int UNUSED_RAS_DEPTH = RAS_DEPTH;
    logic unused_class;
    assign use_ras      = 1'b0;
    assign ras_top      = '0;
    assign unused_class = btb_ret[look_set][hit_way] ^ btb_link[look_set][hit_way];
`endif

    always_comb begin
        next_addr = pc_plus8;
        if (hit && use_ras) begin
            next_addr = ras_top;
        end else if (dir) begin
            next_addr = btb_target[look_set][hit_way];
        end
    end

    always_comb begin
        upd_way = '0;
        for (int w = 0; w < BTB_WAY_NUM; w++) begin
            if (bus.fail_way_vec[w]) upd_way = WAY_W'(w);
        end
    end

    assign upd_existing = bus.update_valid && (|bus.fail_way_vec);
    assign upd_alloc    = bus.update_valid && !(|bus.fail_way_vec) && bus.fill_ghr[0];
    assign wr_way       = upd_existing ? upd_way : rr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < BTB_WAY_NUM; w++)
                    btb_valid[s][w] <= 1'b0;
            for (int g = 0; g < GPT_N; g++) gpt[g] <= GPT_RESET;
            rr_q <= '0;
        end else if (bus.update_valid) begin
            gpt[bus.fail_ghr ^ bus.fail_branch[GLOBAL_WIDTH+1:2]] <= bus.fill_ghr_patten;
            if (upd_alloc) begin
                btb_valid[upd_set][rr_q] <= 1'b1;
                rr_q <= (rr_q == WAY_W'(BTB_WAY_NUM - 1)) ? '0 : rr_q + 1'b1;
            end
        end
    end

    // Entry payload only matters behind a valid bit, so it carries no reset.
    always_ff @(posedge clk) begin
        if (upd_existing || upd_alloc) begin
            btb_hist[upd_set][wr_way] <= bus.fill_pht_history;
            btb_tab[upd_set][wr_way]  <= bus.fill_pht_patten_tab;
            btb_ret[upd_set][wr_way]  <= bus.fill_is_ret;
            btb_link[upd_set][wr_way] <= bus.fill_is_link;
            if (bus.fill_ghr[0]) btb_target[upd_set][wr_way] <= bus.fill_target;
            if (upd_alloc) btb_tag[upd_set][wr_way] <= upd_tag;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr_q <= '0;
        end else if (redirect) begin
            ghr_q <= bus.fill_ghr;
        end else if (hit && !bus.stall) begin
            ghr_q <= {ghr_q[GLOBAL_WIDTH-2:0], dir};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.predict_is_branch <= 1'b0;
            bus.predict_address   <= '0;
            bus.btb_way_vec       <= '0;
            bus.pht_history       <= '0;
            bus.pht_patten_tab    <= '0;
            bus.ghr               <= '0;
            bus.ghr_patten        <= '0;
        end else if (!bus.stall) begin
            bus.predict_is_branch <= dir;
            bus.predict_address   <= next_addr;
            bus.btb_way_vec       <= way_vec;
            bus.pht_history       <= hit ? btb_hist[look_set][hit_way] : '0;
            bus.pht_patten_tab    <= hit ? btb_tab[look_set][hit_way] : '0;
            bus.ghr               <= ghr_q;
            bus.ghr_patten        <= global_ctr;
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit; RAS scenarios run when BPU_RAS_EN is defined.
module tb_branch_predict_unit;

    localparam logic [31:0] MISS_PC = 32'hBFC0_0000;
    localparam logic [31:0] PC_T    = 32'hBFC0_0010;
    localparam logic [31:0] PC_A    = 32'hBFC0_0020;
    localparam logic [31:0] PC_B    = 32'hBFC0_0040;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    branch_predict_unit_if bus ();

    branch_predict_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall               = 1'b0;
        bus.fetch_pc            = MISS_PC;
        bus.update_valid        = 1'b0;
        bus.is_jump_branch      = 1'b0;
        bus.fail_branch         = '0;
        bus.fail_way_vec        = '0;
        bus.fill_target         = '0;
        bus.fill_is_ret         = 1'b0;
        bus.fill_is_link        = 1'b0;
        bus.fill_pht_history    = '0;
        bus.fill_pht_patten_tab = '0;
        bus.fail_ghr            = '0;
        bus.fill_ghr            = '0;
        bus.fill_ghr_patten     = 2'b01;
    endtask

    task automatic drive_update(input logic [31:0] pc, input logic way, input logic [31:0] tgt,
                                input logic ret, input logic link, input logic [3:0] hist,
                                input logic [31:0] tab, input logic [7:0] fghr,
                                input logic [7:0] fail_ghr, input logic [1:0] gpat);
        bus.update_valid        = 1'b1;
        bus.fail_branch         = pc;
        bus.fail_way_vec        = way;
        bus.fill_target         = tgt;
        bus.fill_is_ret         = ret;
        bus.fill_is_link        = link;
        bus.fill_pht_history    = hist;
        bus.fill_pht_patten_tab = tab;
        bus.fill_ghr            = fghr;
        bus.fail_ghr            = fail_ghr;
        bus.fill_ghr_patten     = gpat;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.predict_address !== 32'h0) begin bad++; $display("FAIL rst_addr: got %h want 0", bus.predict_address); end
        total++; if (bus.predict_is_branch !== 1'b0 || bus.btb_way_vec !== 1'b0) begin bad++; $display("FAIL rst_dir_way: got %b/%b want 0/0", bus.predict_is_branch, bus.btb_way_vec); end
        @(negedge clk);
        reset = 1'b1;
        bus.fetch_pc = 32'hBFC0_0000;
        tick();
        total++; if (bus.predict_is_branch !== 1'b0) begin bad++; $display("FAIL miss_dir: got %b want 0", bus.predict_is_branch); end
        total++; if (bus.btb_way_vec !== 1'b0) begin bad++; $display("FAIL miss_way: got %b want 0", bus.btb_way_vec); end
        total++; if (bus.predict_address !== 32'hBFC0_0008) begin bad++; $display("FAIL miss_addr: got %h want bfc00008", bus.predict_address); end
        total++; if (bus.ghr !== 8'h00) begin bad++; $display("FAIL miss_ghr: got %h want 00", bus.ghr); end
        total++; if (bus.ghr_patten !== 2'b01) begin bad++; $display("FAIL gpt_reset: got %b want 01", bus.ghr_patten); end
    endtask

    task automatic test_alloc();
        idle();
        drive_update(PC_T, 1'b0, 32'hBFC0_0100, 1'b0, 1'b0, 4'h0, 32'hFFFF_FFFF, 8'h01, 8'h00, 2'b01);
        tick();
        idle();
        bus.fetch_pc = PC_T;
        tick();
        total++; if (bus.predict_is_branch !== 1'b1) begin bad++; $display("FAIL alloc_dir: got %b want 1", bus.predict_is_branch); end
        total++; if (bus.predict_address !== 32'hBFC0_0100) begin bad++; $display("FAIL alloc_addr: got %h want bfc00100", bus.predict_address); end
        total++; if (bus.btb_way_vec !== 1'b1) begin bad++; $display("FAIL alloc_way: got %b want 1", bus.btb_way_vec); end
        total++; if (bus.pht_patten_tab !== 32'hFFFF_FFFF || bus.pht_history !== 4'h0) begin bad++; $display("FAIL alloc_pht: got %h/%h want ffffffff/0", bus.pht_patten_tab, bus.pht_history); end
        total++; if (bus.ghr !== 8'h00) begin bad++; $display("FAIL alloc_ghr_used: got %h want 00", bus.ghr); end
        tick();
        total++; if (bus.ghr !== 8'h01) begin bad++; $display("FAIL ghr_shift1: got %h want 01", bus.ghr); end
        bus.fetch_pc = MISS_PC;
        tick();
        total++; if (bus.ghr !== 8'h03) begin bad++; $display("FAIL ghr_shift2: got %h want 03", bus.ghr); end
    endtask

    task automatic test_global();
        // GHR is 0x03; lookup of PC_A will index gpt[0x03 ^ 0x08] = gpt[0x0B].
        idle();
        drive_update(PC_A, 1'b0, 32'hBFC0_0200, 1'b0, 1'b0, 4'h2, 32'h0000_0010, 8'h01, 8'h03, 2'b10);
        tick();
        idle();
        bus.fetch_pc = PC_A;
        tick();
        total++; if (bus.predict_is_branch !== 1'b1) begin bad++; $display("FAIL weak_gtaken_dir: got %b want 1", bus.predict_is_branch); end
        total++; if (bus.predict_address !== 32'hBFC0_0200) begin bad++; $display("FAIL weak_gtaken_addr: got %h want bfc00200", bus.predict_address); end
        total++; if (bus.ghr_patten !== 2'b10) begin bad++; $display("FAIL weak_gtaken_gctr: got %b want 10", bus.ghr_patten); end
        // GHR now 0x07 -> gpt[0x0F] still weakly-not-taken
        tick();
        total++; if (bus.predict_is_branch !== 1'b0) begin bad++; $display("FAIL weak_gnt_dir: got %b want 0", bus.predict_is_branch); end
        total++; if (bus.predict_address !== 32'hBFC0_0028) begin bad++; $display("FAIL weak_gnt_addr: got %h want bfc00028", bus.predict_address); end
        total++; if (bus.btb_way_vec !== 1'b1 || bus.ghr !== 8'h07) begin bad++; $display("FAIL weak_gnt_way_ghr: got %b/%h want 1/07", bus.btb_way_vec, bus.ghr); end
        idle();
        drive_update(PC_A, 1'b1, 32'hDEAD_0000, 1'b0, 1'b0, 4'h3, 32'hFFFF_FFFF, 8'h00, 8'h00, 2'b01);
        tick();
        idle();
        bus.fetch_pc = PC_A;
        tick();
        total++; if (bus.predict_address !== 32'hBFC0_0200) begin bad++; $display("FAIL keep_target: got %h want bfc00200", bus.predict_address); end
        total++; if (bus.pht_history !== 4'h3 || bus.predict_is_branch !== 1'b1) begin bad++; $display("FAIL rewrite_hist: got %h/%b want 3/1", bus.pht_history, bus.predict_is_branch); end
        idle();
        drive_update(PC_B, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 4'h0, 32'hFFFF_FFFF, 8'h00, 8'h00, 2'b01);
        tick();
        idle();
        bus.fetch_pc = PC_B;
        tick();
        total++; if (bus.btb_way_vec !== 1'b0 || bus.predict_address !== 32'hBFC0_0048) begin bad++; $display("FAIL no_alloc: got %b/%h want 0/bfc00048", bus.btb_way_vec, bus.predict_address); end
    endtask

    task automatic test_redirect();
        // GHR is 0x1D here
        idle();
        bus.fetch_pc = PC_A;
        drive_update(MISS_PC, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 8'h5A, 8'h00, 2'b01);
        bus.is_jump_branch = 1'b1;
        tick();
        total++; if (bus.ghr !== 8'h1D || bus.predict_is_branch !== 1'b1) begin bad++; $display("FAIL redirect_lookup: got %h/%b want 1d/1", bus.ghr, bus.predict_is_branch); end
        idle();
        tick();
        total++; if (bus.ghr !== 8'h5A) begin bad++; $display("FAIL redirect_ghr: got %h want 5a", bus.ghr); end
    endtask

    task automatic test_stall();
        idle();
        bus.fetch_pc = PC_T;
        tick();
        total++; if (bus.predict_address !== 32'hBFC0_0100 || bus.ghr !== 8'h5A) begin bad++; $display("FAIL stall_pre: got %h/%h want bfc00100/5a", bus.predict_address, bus.ghr); end
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.fetch_pc = (i == 1) ? MISS_PC : PC_T;
            tick();
            total++;
            if (bus.predict_is_branch !== 1'b1 || bus.predict_address !== 32'hBFC0_0100 || bus.ghr !== 8'h5A) begin
                bad++; $display("FAIL stall_hold[%0d]: got %b/%h/%h want 1/bfc00100/5a", i, bus.predict_is_branch, bus.predict_address, bus.ghr);
            end
        end
        idle();
        tick();
        total++; if (bus.ghr !== 8'hB5 || bus.predict_is_branch !== 1'b0) begin bad++; $display("FAIL stall_release: got %h/%b want b5/0", bus.ghr, bus.predict_is_branch); end
    endtask

    task automatic test_mid_reset();
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        total++; if (bus.predict_address !== 32'h0 || bus.ghr !== 8'h00) begin bad++; $display("FAIL async_reset: got %h/%h want 0/0", bus.predict_address, bus.ghr); end
        @(negedge clk);
        reset = 1'b1;
        bus.fetch_pc = PC_T;
        tick();
        total++; if (bus.btb_way_vec !== 1'b0 || bus.predict_is_branch !== 1'b0) begin bad++; $display("FAIL reset_cleared_btb: got %b/%b want 0/0", bus.btb_way_vec, bus.predict_is_branch); end
    endtask

`ifdef BPU_RAS_EN
    task automatic test_ras();
        logic [31:0] lpc;
        idle();
        drive_update(32'h0000_1000, 1'b0, 32'h0000_4000, 1'b0, 1'b1, 4'h0, 32'hFFFF_FFFF, 8'h01, 8'h00, 2'b01);
        tick();
        drive_update(32'h0000_2004, 1'b0, 32'h0000_5000, 1'b1, 1'b0, 4'h0, 32'hFFFF_FFFF, 8'h01, 8'h00, 2'b01);
        tick();
        idle();
        bus.fetch_pc = 32'h0000_1000;
        tick();
        total++; if (bus.predict_address !== 32'h0000_4000) begin bad++; $display("FAIL ras_link_addr: got %h want 4000", bus.predict_address); end
        bus.fetch_pc = 32'h0000_2004;
        tick();
        total++; if (bus.predict_address !== 32'h0000_1008) begin bad++; $display("FAIL ras_ret_addr: got %h want 1008", bus.predict_address); end
        for (int k = 1; k < 9; k++) begin
            idle();
            lpc = 32'h0000_1000 + 32'(8 * k);
            drive_update(lpc, 1'b0, 32'h0000_4000, 1'b0, 1'b1, 4'h0, 32'hFFFF_FFFF, 8'h01, 8'h00, 2'b01);
            tick();
        end
        idle();
        for (int k = 0; k < 9; k++) begin
            bus.fetch_pc = 32'h0000_1000 + 32'(8 * k);
            tick();
        end
        bus.fetch_pc = 32'h0000_2004;
        tick();
        total++; if (bus.predict_address !== 32'h0000_1048) begin bad++; $display("FAIL ras_overflow_pop: got %h want 1048", bus.predict_address); end
        tick();
        total++; if (bus.predict_address !== 32'h0000_1040) begin bad++; $display("FAIL ras_second_pop: got %h want 1040", bus.predict_address); end
        idle();
        tick();
    endtask
`else
    task automatic test_ret_no_ras();
        idle();
        drive_update(32'h0000_2004, 1'b0, 32'h0000_5000, 1'b1, 1'b0, 4'h0, 32'hFFFF_FFFF, 8'h01, 8'h00, 2'b01);
        tick();
        idle();
        bus.fetch_pc = 32'h0000_2004;
        tick();
        total++; if (bus.predict_address !== 32'h0000_5000) begin bad++; $display("FAIL ret_btb_target: got %h want 5000", bus.predict_address); end
        idle();
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_alloc();
        test_global();
        test_redirect();
        test_stall();
        test_mid_reset();
`ifdef BPU_RAS_EN
        test_ras();
`else
        test_ret_no_ras();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
